// File: rtl/dma_copier.sv
// dma_copier: word-granular DMA copier on the data memory request/stall port.
// Sequences one read then one write per 32-bit word, never overlapping accesses.
// Ports:
//   clk, reset (async, active-high)
//   start / abort / src_addr / dst_addr / word_count   control inputs
//   busy / done / error                                status outputs
//   mem_addr / mem_write_data / mem_read / mem_write / mem_sign_mask
//                                                      registered requests
//   mem_read_data / mem_stall                          responder inputs
// Optional macro DMA_FILL_EN adds fill / fill_pattern: write a constant
// pattern to every destination word, skipping the reads.
module dma_copier #(
    parameter int         CNT_W          = 10,
    parameter logic [3:0] WORD_SIGN_MASK = 4'b1111
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [CNT_W-1:0] word_count,
`ifdef DMA_FILL_EN
    input  logic             fill,
    input  logic [31:0]      fill_pattern,
`endif
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_write_data,
    output logic             mem_read,
    output logic             mem_write,
    output logic [3:0]       mem_sign_mask,
    input  logic [31:0]      mem_read_data,
    input  logic             mem_stall
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        DONE
    } state_t;

    state_t           state;
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [CNT_W-1:0] remaining;
    logic             first;
    logic             abort_q;
    logic             fill_q;

    logic             start_fill;
    logic [31:0]      pattern;
    logic             aligned;
    logic             stop;
    logic             wait_exit;

`ifdef DMA_FILL_EN
    assign start_fill = fill;
    assign pattern    = fill_pattern;
`else
    assign start_fill = 1'b0;
    assign pattern    = 32'd0;
`endif

    assign mem_sign_mask = WORD_SIGN_MASK;

    // Source alignment is irrelevant when no reads will be issued.
    assign aligned = (dst_addr[1:0] == 2'b00) &&
                     (start_fill || (src_addr[1:0] == 2'b00));

    // Abort may be a short level; remember it until the access in flight ends.
    assign stop = abort || abort_q;

    // First wait cycle is the responder's guaranteed stall-high cycle.
    assign wait_exit = !first && !mem_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            src            <= '0;
            dst            <= '0;
            remaining      <= '0;
            first          <= 1'b0;
            abort_q        <= 1'b0;
            fill_q         <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
        end else begin
            done      <= 1'b0;
            error     <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (state != IDLE && abort)
                abort_q <= 1'b1;

            unique case (state)
                IDLE: begin
                    abort_q <= 1'b0;
                    if (start) begin
                        if (!aligned) begin
                            error <= 1'b1;
                        end else if (word_count == '0) begin
                            done <= 1'b1;
                        end else begin
                            src       <= src_addr;
                            dst       <= dst_addr;
                            remaining <= word_count;
                            fill_q    <= start_fill;
                            busy      <= 1'b1;
                            if (start_fill) begin
                                mem_write      <= 1'b1;
                                mem_addr       <= dst_addr;
                                mem_write_data <= pattern;
                                state          <= WR_REQ;
                            end else begin
                                mem_read <= 1'b1;
                                mem_addr <= src_addr;
                                state    <= RD_REQ;
                            end
                        end
                    end
                end
                RD_REQ: begin
                    first <= 1'b1;
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    first <= 1'b0;
                    if (wait_exit) begin
                        mem_write_data <= mem_read_data;
                        if (stop) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            mem_write <= 1'b1;
                            mem_addr  <= dst;
                            state     <= WR_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    first <= 1'b1;
                    state <= WR_WAIT;
                end
                WR_WAIT: begin
                    first <= 1'b0;
                    if (wait_exit) begin
                        if (!fill_q)
                            src <= src + 32'd4;
                        dst       <= dst + 32'd4;
                        remaining <= remaining - 1'b1;
                        if (remaining == CNT_W'(1) || stop) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (fill_q) begin
                            mem_write <= 1'b1;
                            mem_addr  <= dst + 32'd4;
                            state     <= WR_REQ;
                        end else begin
                            mem_read <= 1'b1;
                            mem_addr <= src + 32'd4;
                            state    <= RD_REQ;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_copier.sv
// tb_dma_copier: directed and randomized checks of dma_copier against a
// word-level model of the copy, with a behavioural stall-based responder.
module tb_dma_copier;

    localparam int CNT_W = 10;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [CNT_W-1:0] word_count;
`ifdef DMA_FILL_EN
    logic             fill;
    logic [31:0]      fill_pattern;
`endif
    logic             busy;
    logic             done;
    logic             error;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_write_data;
    logic             mem_read;
    logic             mem_write;
    logic [3:0]       mem_sign_mask;
    logic [31:0]      mem_read_data;
    logic             mem_stall;

    int total = 0;
    int bad   = 0;

    dma_copier #(.CNT_W(CNT_W), .WORD_SIGN_MASK(4'b1111)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .src_addr       (src_addr),
        .dst_addr       (dst_addr),
        .word_count     (word_count),
`ifdef DMA_FILL_EN
        .fill           (fill),
        .fill_pattern   (fill_pattern),
`endif
        .busy           (busy),
        .done           (done),
        .error          (error),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_sign_mask  (mem_sign_mask),
        .mem_read_data  (mem_read_data),
        .mem_stall      (mem_stall)
    );

    always #5 clk = ~clk;

    // Memory: unwritten words read as a seeded background function of the
    // address; every completed write lands in wmem.
    logic [31:0] seed = 32'h1234_5678;
    logic [31:0] wmem [logic [31:0]];
    bit          rand_lat = 1'b0;

    int          rd_cnt   = 0;
    int          wr_cnt   = 0;
    int          both_cnt = 0;
    int          lat_sum  = 0;
    int          lat;
    int          cnt;
    logic        op_wr;
    logic [31:0] op_addr;
    logic [31:0] op_data;

    function automatic logic [31:0] bg(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    function automatic logic [31:0] rdm(input logic [31:0] a);
        if (wmem.exists(a))
            return wmem[a];
        return 32'hxxxx_xxxx;
    endfunction

    // Responder: stall rises the cycle after a request and falls after
    // lat-1 stall cycles, giving lat wait cycles seen by the initiator.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt = 0;
            mem_stall     <= 1'b0;
            mem_read_data <= 32'd0;
        end else begin
            if (mem_read && mem_write)
                both_cnt++;
            if (mem_read || mem_write) begin
                lat = rand_lat ? int'($urandom_range(4, 2)) : 3;
                lat_sum += lat;
                cnt     = lat - 1;
                op_wr   = mem_write;
                op_addr = mem_addr;
                op_data = mem_write_data;
                if (mem_read)
                    rd_cnt++;
                else
                    wr_cnt++;
                mem_stall <= 1'b1;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    mem_stall <= 1'b0;
                    if (op_wr)
                        wmem[op_addr] = op_data;
                    else
                        mem_read_data <= wmem.exists(op_addr) ?
                                         wmem[op_addr] : bg(op_addr);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic kick(input logic [31:0] s, input logic [31:0] d,
                        input int n, input bit f, input logic [31:0] p);
        @(negedge clk);
        src_addr   = s;
        dst_addr   = d;
        word_count = CNT_W'(n);
`ifdef DMA_FILL_EN
        fill         = f;
        fill_pattern = p;
`else
        if (f)
            dst_addr = d ^ p ^ p;
`endif
        start = 1'b1;
    endtask

    // Observes cycle k (k = 1 is the first cycle after the start cycle).
    task automatic wait_done(input int abort_at, input int spur,
                             output int cyc, output logic b1);
        cyc = -1;
        b1  = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            start = (k == spur);
            if (k == spur) begin
                src_addr   = 32'h0000_0F00;
                dst_addr   = 32'h0000_0E00;
                word_count = CNT_W'(1);
            end
            if (k == abort_at)
                abort = 1'b1;
            if (k == 1)
                b1 = busy;
            if (done) begin
                cyc = k;
                break;
            end
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    task automatic run_copy(input logic [31:0] s, input logic [31:0] d,
                            input int n, input bit f,
                            input logic [31:0] p, input bit rl,
                            input int spur, output int cyc);
        int   rd0;
        int   wr0;
        int   both0;
        int   lat0;
        logic b1;
        rd0      = rd_cnt;
        wr0      = wr_cnt;
        both0    = both_cnt;
        lat0     = lat_sum;
        rand_lat = rl;
        kick(s, d, n, f, p);
        wait_done(0, spur, cyc, b1);
        check("busy_after_start", b1, 1);
        check("busy_at_done", busy, 0);
        check("read_count", rd_cnt - rd0, f ? 0 : n);
        check("write_count", wr_cnt - wr0, n);
        check("rd_wr_overlap", both_cnt - both0, 0);
        check("done_cycle", cyc, (f ? 1 : 2) * n + (lat_sum - lat0) + 1);
        for (int i = 0; i < n; i++)
            check("dst_word", rdm(d + 32'(4 * i)), f ? p : bg(s + 32'(4 * i)));
        check("dst_past_end_untouched", 32'(wmem.exists(d + 32'(4 * n))), 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        int          cyc;
        int          rd0;
        int          wr0;
        logic        b1;
        logic [31:0] s;
        logic [31:0] d;
        int          n;

        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        src_addr   = '0;
        dst_addr   = '0;
        word_count = '0;
`ifdef DMA_FILL_EN
        fill         = 1'b0;
        fill_pattern = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_write_data, 0);
        check("sign_mask", mem_sign_mask, 4'b1111);
        reset = 1'b0;

        // Four-word copy with a 3-cycle responder, plus a start while busy.
        run_copy(32'h1000, 32'h1100, 4, 1'b0, 32'd0, 1'b0, 12, cyc);
        check("copy4_done_at_33", cyc, 33);
        check("spurious_start_no_write", 32'(wmem.exists(32'h0E00)), 0);

        // Zero-length transfer: done only, no accesses.
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        kick(32'h5000, 32'h5100, 0, 1'b0, 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        repeat (4) @(negedge clk);
        check("zero_done_once", done, 0);
        check("zero_requests", (rd_cnt - rd0) + (wr_cnt - wr0), 0);

        // Misaligned source: error pulse, nothing else.
        kick(32'h1002, 32'h1100, 4, 1'b0, 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("misalign_error", error, 1);
        check("misalign_busy", busy, 0);
        check("misalign_done", done, 0);
        repeat (4) @(negedge clk);
        check("misalign_error_once", error, 0);
        check("misalign_busy_later", busy, 0);
        check("misalign_requests", (rd_cnt - rd0) + (wr_cnt - wr0), 0);

        // Abort during the read of word 2 of 5.
        rand_lat = 1'b0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        kick(32'h3000, 32'h3100, 5, 1'b0, 32'd0);
        wait_done(9, 0, cyc, b1);
        check("abort_done_cycle", cyc, 13);
        check("abort_busy", busy, 0);
        repeat (6) @(negedge clk);
        check("abort_reads", rd_cnt - rd0, 2);
        check("abort_writes", wr_cnt - wr0, 1);
        check("abort_word0", rdm(32'h3100), bg(32'h3000));
        check("abort_word1_untouched", 32'(wmem.exists(32'h3104)), 0);

        // Reset in the first WR_WAIT cycle of a two-word copy.
        kick(32'h4000, 32'h4100, 2, 1'b0, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_error", error, 0);
        check("midrst_mem_read", mem_read, 0);
        check("midrst_mem_write", mem_write, 0);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_mem_wdata", mem_write_data, 0);
        @(negedge clk);
        reset = 1'b0;
        run_copy(32'h4200, 32'h4300, 1, 1'b0, 32'd0, 1'b0, 0, cyc);
        check("after_rst_done_at_9", cyc, 9);
        check("midrst_write_dropped", 32'(wmem.exists(32'h4100)), 0);

`ifdef DMA_FILL_EN
        run_copy(32'h0, 32'h1200, 3, 1'b1, 32'hDEAD_BEEF, 1'b0, 0, cyc);
        check("fill_done_at_13", cyc, 13);
`endif

        // Randomized copies: random data, placement, length and latency.
        for (int it = 0; it < 8; it++) begin
            seed = $urandom;
            s = 32'h0002_0000 + 32'(it) * 32'h1000 + 32'($urandom_range(63)) * 4;
            d = 32'h0002_0800 + 32'(it) * 32'h1000 + 32'($urandom_range(63)) * 4;
            n = int'($urandom_range(8, 1));
            run_copy(s, d, n, 1'b0, 32'd0, 1'b1, 0, cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
